// File: rtl/high_freq_fir.sv
// Stereo FIR multiply-accumulate engine: one ROM coefficient per captured sample,
// accumulated per burst and emitted as a scaled, saturated 16-bit result with a valid strobe.
module high_freq_fir #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sequencing,
  input  logic [15:0]       lft_in,
  input  logic [15:0]       rght_in,
  input  logic [15:0]       coeff,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic [15:0]       lft_out,
  output logic [15:0]       rght_out,
  output logic              valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                drain_q, drain_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cap;
  logic                acc_clr;

  logic signed [15:0]  smpl_l_q, smpl_r_q;
  logic                v1_q, v2_q;
  logic signed [31:0]  prod_l_q, prod_r_q;
  logic signed [31:0]  acc_l_q, acc_r_q;
  logic [15:0]         lft_out_q, rght_out_q;
  logic [15:0]         sat_l, sat_r;

  // Samples arriving in DRAIN/OUT are a protocol violation and are simply dropped.
  assign cap     = sequencing & ((state_q == IDLE) | (state_q == RUN));
  assign acc_clr = (state_q == IDLE) & sequencing;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    addr_d  = addr_q;
    if (cap) addr_d = addr_q + 1'b1;
    unique case (state_q)
      IDLE:  if (sequencing) state_d = RUN;
      RUN:   if (!sequencing) begin
               state_d = DRAIN;
               drain_d = 1'b0;
             end
      DRAIN: begin
               drain_d = ~drain_q;
               if (drain_q) state_d = OUT;
             end
      OUT:   begin
               state_d = IDLE;
               addr_d  = '0;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_l_q <= '0;
      smpl_r_q <= '0;
      v1_q     <= 1'b0;
      prod_l_q <= '0;
      prod_r_q <= '0;
      v2_q     <= 1'b0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
    end else begin
      v1_q <= cap;
      if (cap) begin
        smpl_l_q <= lft_in;
        smpl_r_q <= rght_in;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        prod_l_q <= smpl_l_q * $signed(coeff);
        prod_r_q <= smpl_r_q * $signed(coeff);
      end
      // The first product lands one edge after the clear, so clear never races an add.
      if (acc_clr) begin
        acc_l_q <= '0;
        acc_r_q <= '0;
      end else if (v2_q) begin
        acc_l_q <= acc_l_q + prod_l_q;
        acc_r_q <= acc_r_q + prod_r_q;
      end
    end
  end

  always_comb begin
    sat_l = acc_l_q[30:15];
    sat_r = acc_r_q[30:15];
    if (acc_l_q[31:30] == 2'b01) sat_l = 16'h7FFF;
    if (acc_l_q[31:30] == 2'b10) sat_l = 16'h8000;
    if (acc_r_q[31:30] == 2'b01) sat_r = 16'h7FFF;
    if (acc_r_q[31:30] == 2'b10) sat_r = 16'h8000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_out_q  <= '0;
      rght_out_q <= '0;
    end else if ((state_q == DRAIN) && drain_q) begin
      lft_out_q  <= sat_l;
      rght_out_q <= sat_r;
    end
  end

  assign coeff_addr = addr_q;
  assign lft_out    = lft_out_q;
  assign rght_out   = rght_out_q;
  assign valid      = (state_q == OUT);

endmodule
